// File: rtl/cbus_rr_arbiter_pkg.sv
// Shared types for the CBus arbiter: the CBus request/response records used by
// every master and the downstream port, plus the arbiter FSM state.
package cbus_rr_arbiter_pkg;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [3:0]  strobe;
        logic [31:0] data;
        logic [3:0]  len;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEL  = 2'd1,
        BUSY = 2'd2
    } cbus_arb_state_t;

    // Index width for n masters; a single master still gets a 1-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cbus_rr_arbiter_rr_pick.sv
// Combinational rotating-priority picker: first valid index at or after i_ptr,
// wrapping modulo N. Shared by the CBus arbiter and intended for other arbiters.
module rr_pick #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [IDX_W-1:0] i_ptr,
    input  logic [N-1:0]     i_valid,
    output logic             o_found,
    output logic [IDX_W-1:0] o_index
);

    localparam logic [IDX_W:0] LP_N = (IDX_W+1)'(N);

    logic [IDX_W:0] w_dist [N];
    logic [IDX_W:0] w_best_dist;

    // Distance of each input from the pointer, going forward with wrap-around.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_dist
            localparam logic [IDX_W:0] LP_I = (IDX_W+1)'(gi);
            assign w_dist[gi] = (LP_I >= {1'b0, i_ptr}) ? (LP_I - {1'b0, i_ptr})
                                                        : (LP_I + LP_N - {1'b0, i_ptr});
        end
    endgenerate

    always_comb begin
        o_found     = 1'b0;
        o_index     = '0;
        w_best_dist = LP_N;
        for (int i = 0; i < N; i++) begin
            if (i_valid[i] && (w_dist[i] < w_best_dist)) begin
                w_best_dist = w_dist[i];
                o_found     = 1'b1;
                o_index     = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/cbus_rr_arbiter.sv
// N:1 CBus arbiter. The winning master owns the downstream port until the
// burst's final beat; selection is fixed-priority or round-robin.
module cbus_rr_arbiter
    import cbus_rr_arbiter_pkg::*;
#(
    parameter int  NUM_INPUTS   = 2,
    parameter int  ROUND_ROBIN  = 1,
    parameter int  ZERO_LATENCY = 1,
    localparam int IDX_W        = idx_width(NUM_INPUTS)
) (
    input  logic                             clk,
    input  logic                             resetn,
    input  cbus_req_t  [NUM_INPUTS-1:0]      ireqs,
    output cbus_resp_t [NUM_INPUTS-1:0]      iresps,
    output cbus_req_t                        oreq,
    input  cbus_resp_t                       oresp,
    output logic                             busy,
    output logic       [IDX_W-1:0]           owner
);

    localparam logic [IDX_W-1:0] LP_LAST = IDX_W'(NUM_INPUTS - 1);

    cbus_arb_state_t    r_state;
    logic [IDX_W-1:0]   r_owner;
    logic [IDX_W-1:0]   r_ptr;
    logic [IDX_W-1:0]   r_sel_q;

    logic [NUM_INPUTS-1:0] w_valid;
    logic                  w_found;
    logic [IDX_W-1:0]      w_pick;
    logic                  w_grant;
    logic [IDX_W-1:0]      w_grant_idx;

    generate
        for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_valid
            assign w_valid[gi] = ireqs[gi].valid;
        end
    endgenerate

    rr_pick #(
        .N     (NUM_INPUTS),
        .IDX_W (IDX_W)
    ) u_pick (
        .i_ptr   (r_ptr),
        .i_valid (w_valid),
        .o_found (w_found),
        .o_index (w_pick)
    );

    // Which master currently drives the downstream port, if any.
    always_comb begin
        w_grant     = 1'b0;
        w_grant_idx = '0;
        case (r_state)
            IDLE: begin
                if ((ZERO_LATENCY != 0) && w_found) begin
                    w_grant     = 1'b1;
                    w_grant_idx = w_pick;
                end
            end
            SEL: begin
                w_grant     = 1'b1;
                w_grant_idx = r_sel_q;
            end
            BUSY: begin
                w_grant     = 1'b1;
                w_grant_idx = r_owner;
            end
            default: begin
                w_grant     = 1'b0;
                w_grant_idx = '0;
            end
        endcase
    end

    // Outputs are forced quiet while reset is held, even in the zero-latency path.
    always_comb begin
        oreq   = '0;
        iresps = '0;
        if (resetn && w_grant) begin
            oreq                = ireqs[w_grant_idx];
            iresps[w_grant_idx] = oresp;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
            r_owner <= '0;
            r_ptr   <= '0;
            r_sel_q <= '0;
        end else begin
            if ((ROUND_ROBIN != 0) && w_grant && oresp.last) begin
                r_ptr <= (w_grant_idx == LP_LAST) ? '0 : (w_grant_idx + 1'b1);
            end
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        if (ZERO_LATENCY != 0) begin
                            if (!oresp.last) begin
                                r_state <= BUSY;
                                r_owner <= w_pick;
                            end
                        end else begin
                            r_state <= SEL;
                            r_sel_q <= w_pick;
                        end
                    end
                end
                SEL: begin
                    if (oresp.last) begin
                        r_state <= IDLE;
                    end else begin
                        r_state <= BUSY;
                        r_owner <= r_sel_q;
                    end
                end
                BUSY: begin
                    if (oresp.last) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy  = (r_state == BUSY);
    assign owner = r_owner;

    // The locked owner must hold its request until its last beat.
    a_owner_holds_valid: assert property (
        @(posedge clk) disable iff (!resetn)
        (r_state == BUSY) |-> ireqs[r_owner].valid
    );

endmodule

// File: tb/tb_cbus_rr_arbiter.sv
// Directed bench for cbus_rr_arbiter: a vector table on a 2-input round-robin
// instance plus short hand sequences on 3-input and registered-select instances.
module tb_cbus_rr_arbiter;
    import cbus_rr_arbiter_pkg::*;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // A: N=2 RR ZL
    cbus_req_t  [1:0] a_ireqs;
    cbus_resp_t [1:0] a_iresps;
    cbus_req_t        a_oreq;
    cbus_resp_t       a_oresp;
    logic             a_busy;
    logic [0:0]       a_owner;
    // B: N=3 RR ZL
    cbus_req_t  [2:0] b_ireqs;
    cbus_resp_t [2:0] b_iresps;
    cbus_req_t        b_oreq;
    cbus_resp_t       b_oresp;
    logic             b_busy;
    logic [1:0]       b_owner;
    // C: N=3 fixed priority ZL
    cbus_req_t  [2:0] c_ireqs;
    cbus_resp_t [2:0] c_iresps;
    cbus_req_t        c_oreq;
    cbus_resp_t       c_oresp;
    logic             c_busy;
    logic [1:0]       c_owner;
    // D: N=2 RR registered select
    cbus_req_t  [1:0] d_ireqs;
    cbus_resp_t [1:0] d_iresps;
    cbus_req_t        d_oreq;
    cbus_resp_t       d_oresp;
    logic             d_busy;
    logic [0:0]       d_owner;

    cbus_rr_arbiter #(.NUM_INPUTS(2), .ROUND_ROBIN(1), .ZERO_LATENCY(1)) u_a (
        .clk(clk), .resetn(resetn), .ireqs(a_ireqs), .iresps(a_iresps),
        .oreq(a_oreq), .oresp(a_oresp), .busy(a_busy), .owner(a_owner));
    cbus_rr_arbiter #(.NUM_INPUTS(3), .ROUND_ROBIN(1), .ZERO_LATENCY(1)) u_b (
        .clk(clk), .resetn(resetn), .ireqs(b_ireqs), .iresps(b_iresps),
        .oreq(b_oreq), .oresp(b_oresp), .busy(b_busy), .owner(b_owner));
    cbus_rr_arbiter #(.NUM_INPUTS(3), .ROUND_ROBIN(0), .ZERO_LATENCY(1)) u_c (
        .clk(clk), .resetn(resetn), .ireqs(c_ireqs), .iresps(c_iresps),
        .oreq(c_oreq), .oresp(c_oresp), .busy(c_busy), .owner(c_owner));
    cbus_rr_arbiter #(.NUM_INPUTS(2), .ROUND_ROBIN(1), .ZERO_LATENCY(0)) u_d (
        .clk(clk), .resetn(resetn), .ireqs(d_ireqs), .iresps(d_iresps),
        .oreq(d_oreq), .oresp(d_oresp), .busy(d_busy), .owner(d_owner));

    function automatic cbus_req_t mk_req(input logic [31:0] addr);
        cbus_req_t r;
        r.valid    = 1'b1;
        r.is_write = addr[4];
        r.size     = 3'd2;
        r.addr     = addr;
        r.strobe   = 4'hF;
        r.data     = ~addr;
        r.len      = 4'd3;
        return r;
    endfunction

    function automatic cbus_resp_t mk_resp(input logic rdy, input logic lst, input logic [31:0] d);
        cbus_resp_t r;
        r.ready = rdy;
        r.last  = lst;
        r.data  = d;
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] A0 = 32'h0000_1000, A1 = 32'h0000_2010;

    typedef struct {
        logic v0, v1, rdy, lst;
        int   gnt;          // expected granted input, -1 = none
        logic busy;
        logic owner;
    } vec_t;

    vec_t vt [15];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

    initial begin : main
        cbus_req_t        exp_req;
        cbus_resp_t [1:0] exp_r2;
        cbus_resp_t [2:0] exp_r3;
        logic [31:0]      b_addr [3];
        logic [31:0]      c_addr [3];
        logic [31:0]      d_addr [2];
        int               order [6];

        vt[0]  = '{1'b1, 1'b1, 1'b1, 1'b0,  0, 1'b0, 1'b0};
        vt[1]  = '{1'b1, 1'b1, 1'b1, 1'b0,  0, 1'b1, 1'b0};
        vt[2]  = '{1'b1, 1'b1, 1'b1, 1'b0,  0, 1'b1, 1'b0};
        vt[3]  = '{1'b1, 1'b1, 1'b1, 1'b1,  0, 1'b1, 1'b0};
        vt[4]  = '{1'b0, 1'b1, 1'b1, 1'b0,  1, 1'b0, 1'b0};
        vt[5]  = '{1'b1, 1'b1, 1'b1, 1'b0,  1, 1'b1, 1'b1};
        vt[6]  = '{1'b1, 1'b1, 1'b1, 1'b0,  1, 1'b1, 1'b1};
        vt[7]  = '{1'b1, 1'b1, 1'b1, 1'b1,  1, 1'b1, 1'b1};
        vt[8]  = '{1'b1, 1'b1, 1'b1, 1'b1,  0, 1'b0, 1'b1};
        vt[9]  = '{1'b1, 1'b1, 1'b0, 1'b0,  1, 1'b0, 1'b1};
        vt[10] = '{1'b1, 1'b1, 1'b1, 1'b1,  1, 1'b1, 1'b1};
        vt[11] = '{1'b0, 1'b0, 1'b0, 1'b0, -1, 1'b0, 1'b1};
        vt[12] = '{1'b0, 1'b1, 1'b1, 1'b1,  1, 1'b0, 1'b1};
        vt[13] = '{1'b1, 1'b1, 1'b0, 1'b0,  0, 1'b0, 1'b1};
        vt[14] = '{1'b1, 1'b1, 1'b1, 1'b1,  0, 1'b1, 1'b0};

        b_addr = '{32'h0000_B100, 32'h0000_B200, 32'h0000_B300};
        c_addr = '{32'h0000_C100, 32'h0000_C210, 32'h0000_C300};
        d_addr = '{32'h0000_D100, 32'h0000_D210};
        order  = '{0, 1, 2, 0, 1, 2};

        b_ireqs = '0; b_oresp = '0;
        c_ireqs = '0; c_oresp = '0;
        d_ireqs = '0; d_oresp = '0;

        // Reset: outputs quiet even with requests present.
        a_ireqs[0] = mk_req(A0);
        a_ireqs[1] = mk_req(A1);
        a_oresp    = mk_resp(1'b1, 1'b0, 32'hAAAA_0001);
        #12;
        chk("reset_oreq",   128'(a_oreq),   128'(0));
        chk("reset_iresps", 128'(a_iresps), 128'(0));
        chk("reset_busy",   128'(a_busy),   128'(0));
        chk("reset_owner",  128'(a_owner),  128'(0));
        $display("[TB] reset state checked");
        a_ireqs = '0;
        a_oresp = '0;
        @(negedge clk);
        resetn = 1'b1;
        tick();

        // Vector table on instance A.
        for (int r = 0; r < 15; r++) begin
            a_ireqs[0] = vt[r].v0 ? mk_req(A0) : cbus_req_t'(0);
            a_ireqs[1] = vt[r].v1 ? mk_req(A1) : cbus_req_t'(0);
            a_oresp    = mk_resp(vt[r].rdy, vt[r].lst, 32'hCAFE_0000 + 32'(r));
            @(negedge clk);
            exp_req   = (vt[r].gnt == 0) ? mk_req(A0) : (vt[r].gnt == 1) ? mk_req(A1) : cbus_req_t'(0);
            exp_r2[0] = (vt[r].gnt == 0) ? a_oresp : cbus_resp_t'(0);
            exp_r2[1] = (vt[r].gnt == 1) ? a_oresp : cbus_resp_t'(0);
            chk($sformatf("row%0d_oreq", r),   128'(a_oreq),   128'(exp_req));
            chk($sformatf("row%0d_iresps", r), 128'(a_iresps), 128'(exp_r2));
            chk($sformatf("row%0d_busy", r),   128'(a_busy),   128'(vt[r].busy));
            chk($sformatf("row%0d_owner", r),  128'(a_owner),  128'(vt[r].owner));
            $display("[TB] row %0d: gnt=%0d busy=%0b owner=%0d", r, vt[r].gnt, a_busy, a_owner);
            tick();
        end
        a_ireqs = '0;
        a_oresp = '0;
        tick();

        // B: three masters always requesting, one-beat bursts completing a cycle after issue.
        for (int i = 0; i < 3; i++) b_ireqs[i] = mk_req(b_addr[i]);
        for (int g = 0; g < 6; g++) begin
            b_oresp = mk_resp(1'b0, 1'b0, 32'hBEEF_0000 + 32'(g));
            @(negedge clk);
            chk($sformatf("rr3_issue%0d_oreq", g), 128'(b_oreq), 128'(mk_req(b_addr[order[g]])));
            chk($sformatf("rr3_issue%0d_busy", g), 128'(b_busy), 128'(0));
            tick();
            b_oresp = mk_resp(1'b1, 1'b1, 32'hBEEF_1000 + 32'(g));
            @(negedge clk);
            exp_r3 = '0;
            exp_r3[order[g]] = b_oresp;
            chk($sformatf("rr3_beat%0d_owner", g),  128'(b_owner),  128'(order[g]));
            chk($sformatf("rr3_beat%0d_busy", g),   128'(b_busy),   128'(1));
            chk($sformatf("rr3_beat%0d_iresps", g), 128'(b_iresps), 128'(exp_r3));
            $display("[TB] rr3 grant %0d -> input %0d", g, b_owner);
            tick();
        end
        b_ireqs = '0;
        b_oresp = '0;
        tick();

        // C: fixed priority, in2 locked while in0/in1 arrive.
        c_ireqs[2] = mk_req(c_addr[2]);
        c_oresp    = mk_resp(1'b1, 1'b0, 32'hC0DE_0001);
        @(negedge clk);
        chk("fp_issue2_oreq", 128'(c_oreq), 128'(mk_req(c_addr[2])));
        tick();
        c_ireqs[0] = mk_req(c_addr[0]);
        c_ireqs[1] = mk_req(c_addr[1]);
        c_oresp    = mk_resp(1'b1, 1'b0, 32'hC0DE_0002);
        @(negedge clk);
        exp_r3 = '0;
        exp_r3[2] = c_oresp;
        chk("fp_lock_oreq",   128'(c_oreq),   128'(mk_req(c_addr[2])));
        chk("fp_lock_owner",  128'(c_owner),  128'(2));
        chk("fp_lock_busy",   128'(c_busy),   128'(1));
        chk("fp_lock_iresps", 128'(c_iresps), 128'(exp_r3));
        tick();
        c_oresp = mk_resp(1'b1, 1'b1, 32'hC0DE_0003);
        @(negedge clk);
        chk("fp_last2_oreq", 128'(c_oreq), 128'(mk_req(c_addr[2])));
        $display("[TB] fp burst on in2 held through last");
        tick();
        c_ireqs[2] = '0;
        c_oresp    = mk_resp(1'b1, 1'b0, 32'hC0DE_0004);
        @(negedge clk);
        chk("fp_next_oreq", 128'(c_oreq), 128'(mk_req(c_addr[0])));
        chk("fp_next_busy", 128'(c_busy), 128'(0));
        tick();
        c_oresp = mk_resp(1'b1, 1'b1, 32'hC0DE_0005);
        @(negedge clk);
        chk("fp_in0_owner", 128'(c_owner), 128'(0));
        $display("[TB] fp in0 served after in2");
        tick();
        c_oresp = mk_resp(1'b1, 1'b1, 32'hC0DE_0006);
        @(negedge clk);
        chk("fp_in0_again_oreq", 128'(c_oreq), 128'(mk_req(c_addr[0])));
        tick();
        c_ireqs[0] = '0;
        c_oresp    = mk_resp(1'b1, 1'b1, 32'hC0DE_0007);
        @(negedge clk);
        chk("fp_in1_oreq", 128'(c_oreq), 128'(mk_req(c_addr[1])));
        $display("[TB] fp in1 served last");
        tick();
        c_ireqs = '0;
        c_oresp = '0;
        @(negedge clk);
        chk("fp_idle_oreq", 128'(c_oreq), 128'(0));
        tick();

        // D: registered select adds one cycle before issue.
        d_ireqs[1] = mk_req(d_addr[1]);
        d_oresp    = mk_resp(1'b0, 1'b0, 32'hD00D_0001);
        @(negedge clk);
        chk("zl0_arrive_oreq",   128'(d_oreq),   128'(0));
        chk("zl0_arrive_iresps", 128'(d_iresps), 128'(0));
        chk("zl0_arrive_busy",   128'(d_busy),   128'(0));
        tick();
        d_oresp = mk_resp(1'b1, 1'b0, 32'hD00D_0002);
        @(negedge clk);
        exp_r2 = '0;
        exp_r2[1] = d_oresp;
        chk("zl0_sel_oreq",   128'(d_oreq),   128'(mk_req(d_addr[1])));
        chk("zl0_sel_iresps", 128'(d_iresps), 128'(exp_r2));
        tick();
        d_oresp = mk_resp(1'b1, 1'b1, 32'hD00D_0003);
        @(negedge clk);
        chk("zl0_busy_busy",  128'(d_busy),  128'(1));
        chk("zl0_busy_owner", 128'(d_owner), 128'(1));
        chk("zl0_busy_oreq",  128'(d_oreq),  128'(mk_req(d_addr[1])));
        $display("[TB] zl0 request on in1 issued one cycle late");
        tick();
        d_ireqs = '0;
        d_oresp = '0;
        @(negedge clk);
        chk("zl0_done_oreq", 128'(d_oreq), 128'(0));
        chk("zl0_done_busy", 128'(d_busy), 128'(0));
        tick();

        // A: reset asserted mid-cycle in the second beat of a burst. ptr is 1 here.
        a_ireqs[0] = mk_req(A0);
        a_oresp    = mk_resp(1'b1, 1'b0, 32'hFEED_0001);
        @(negedge clk);
        chk("rst_issue_oreq", 128'(a_oreq), 128'(mk_req(A0)));
        tick();
        a_ireqs[1] = mk_req(A1);
        a_oresp    = mk_resp(1'b1, 1'b0, 32'hFEED_0002);
        #2;
        chk("rst_pre_busy", 128'(a_busy), 128'(1));
        resetn = 1'b0;
        #1;
        chk("rst_mid_busy",   128'(a_busy),   128'(0));
        chk("rst_mid_oreq",   128'(a_oreq),   128'(0));
        chk("rst_mid_iresps", 128'(a_iresps), 128'(0));
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        #1;
        chk("rst_rel_oreq", 128'(a_oreq), 128'(mk_req(A0)));
        chk("rst_rel_busy", 128'(a_busy), 128'(0));
        tick();
        a_oresp = mk_resp(1'b1, 1'b1, 32'hFEED_0003);
        @(negedge clk);
        chk("rst_new_busy",  128'(a_busy),  128'(1));
        chk("rst_new_owner", 128'(a_owner), 128'(0));
        $display("[TB] reset mid-burst then fresh issue on in0");
        tick();
        a_ireqs = '0;
        a_oresp = '0;
        @(negedge clk);
        chk("rst_end_busy", 128'(a_busy), 128'(0));
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
